// File: rtl/adc_spi_engine.sv
// Multi-lane SPI readout engine for a single ADC: conversion readouts and register frames,
// with configurable chip-select setup/hold and a valid/ready result register.
module adc_spi_engine #(
    parameter int unsigned NUM_SDI       = 4,
    parameter int unsigned CNV_BITS      = 32,
    parameter int unsigned REG_BITS      = 24,
    parameter int unsigned REG_DATA_BITS = 8,
    parameter int unsigned CS_SETUP      = 1,
    parameter int unsigned CS_HOLD       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SDI-1:0]       spi_sdi,
    output logic                     spi_sdo,
    output logic                     spi_csn,
    output logic                     spi_clk_en,
    input  logic                     start_acq,
    input  logic                     start_reg,
    input  logic [REG_BITS-1:0]      reg_cmd,
    output logic [REG_DATA_BITS-1:0] reg_rdata,
    output logic                     reg_done,
    output logic [CNV_BITS-1:0]      cnv_data,
    output logic                     cnv_valid,
    input  logic                     cnv_ready,
    output logic                     overrun,
    input  logic                     clear_overrun,
    output logic                     busy
);

    localparam int unsigned ACQ_N   = CNV_BITS / NUM_SDI;
    localparam int unsigned MAX_XF  = (ACQ_N > REG_BITS) ? ACQ_N : REG_BITS;
    localparam int unsigned MAX_CS  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned MAX_ALL = (MAX_XF > MAX_CS) ? MAX_XF : MAX_CS;
    localparam int unsigned CW      = $clog2(MAX_ALL) + 1;

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]            cnt_q, cnt_d;    // bits/beats left in the frame
    logic [CW-1:0]            wait_q, wait_d;  // CS setup/hold cycles left
    logic                     acq_q, acq_d;
    logic [CNV_BITS-1:0]      shift_q, shift_d;
    logic [CNV_BITS-1:0]      cnv_data_q, cnv_data_d;
    logic [REG_BITS-1:0]      cmd_q, cmd_d;
    logic [REG_DATA_BITS-1:0] rdata_q, rdata_d;
    logic                     sdo_q, sdo_d;
    logic                     csn_q, csn_d;
    logic                     clk_en_q, clk_en_d;
    logic                     done_q, done_d;
    logic                     valid_q, valid_d;
    logic                     ovr_q, ovr_d;
    logic [NUM_SDI-1:0]       lanes;

    // sdi[0] carries the most significant bit of each beat
    always_comb begin
        lanes = '0;
        for (int i = 0; i < int'(NUM_SDI); i++) begin
            lanes[NUM_SDI-1-i] = spi_sdi[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wait_q     <= '0;
            acq_q      <= 1'b0;
            shift_q    <= '0;
            cnv_data_q <= '0;
            cmd_q      <= '0;
            rdata_q    <= '0;
            sdo_q      <= 1'b0;
            csn_q      <= 1'b1;
            clk_en_q   <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            acq_q      <= acq_d;
            shift_q    <= shift_d;
            cnv_data_q <= cnv_data_d;
            cmd_q      <= cmd_d;
            rdata_q    <= rdata_d;
            sdo_q      <= sdo_d;
            csn_q      <= csn_d;
            clk_en_q   <= clk_en_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_acq || start_reg) begin
                    state_d = (CS_SETUP == 0) ? StXfer : StSetup;
                end
            end
            StSetup: begin
                if (wait_q == '0) state_d = StXfer;
            end
            StXfer: begin
                if (cnt_q == '0) state_d = (CS_HOLD == 0) ? StIdle : StHold;
            end
            StHold: begin
                if (wait_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        acq_d      = acq_q;
        shift_d    = shift_q;
        cnv_data_d = cnv_data_q;
        cmd_d      = cmd_q;
        rdata_d    = rdata_q;
        sdo_d      = sdo_q;
        csn_d      = csn_q;
        clk_en_d   = clk_en_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        ovr_d      = ovr_q;

        if (valid_q && cnv_ready) valid_d = 1'b0;
        if (clear_overrun) ovr_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_acq || start_reg) begin
                    csn_d    = 1'b0;
                    acq_d    = start_acq;
                    wait_d   = CW'((CS_SETUP == 0) ? 0 : CS_SETUP - 1);
                    clk_en_d = (CS_SETUP == 0);
                    if (start_acq) begin
                        cnt_d   = CW'(ACQ_N);
                        sdo_d   = 1'b0;
                        shift_d = '0;
                    end else begin
                        cnt_d = CW'(REG_BITS);
                        sdo_d = reg_cmd[REG_BITS-1];
                        cmd_d = reg_cmd;
                    end
                end
            end
            StSetup: begin
                if (wait_q == '0) clk_en_d = 1'b1;
                else wait_d = wait_q - CW'(1);
            end
            StXfer: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) clk_en_d = 1'b0;
                    if (acq_q) begin
                        shift_d = {shift_q[CNV_BITS-NUM_SDI-1:0], lanes};
                    end else begin
                        // A zero shifts in behind the command, so sdo idles low after the last bit
                        sdo_d = cmd_q[REG_BITS-2];
                        cmd_d = cmd_q << 1;
                        if (cnt_q <= CW'(REG_DATA_BITS)) begin
                            rdata_d = {rdata_q[REG_DATA_BITS-2:0], spi_sdi[0]};
                        end
                    end
                end else begin
                    csn_d  = 1'b1;
                    wait_d = CW'((CS_HOLD == 0) ? 0 : CS_HOLD - 1);
                    if (acq_q) begin
                        cnv_data_d = shift_q;
                        valid_d    = 1'b1;
                        // Set after the clear above so a simultaneous set wins
                        if (valid_q && !cnv_ready) ovr_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (wait_q != '0) wait_d = wait_q - CW'(1);
            end
            default: ;
        endcase
    end

    assign spi_sdo    = sdo_q;
    assign spi_csn    = csn_q;
    assign spi_clk_en = clk_en_q;
    assign reg_rdata  = rdata_q;
    assign reg_done   = done_q;
    assign cnv_data   = cnv_data_q;
    assign cnv_valid  = valid_q;
    assign overrun    = ovr_q;
    assign busy       = reset || (state_q != StIdle);

endmodule

// File: tb/tb_adc_spi_engine.sv
// Scoreboard bench for adc_spi_engine: default 4-lane instance plus a 1-lane instance with
// zero chip-select setup/hold.
module tb_adc_spi_engine;

    logic        clk;
    logic        reset;
    logic [3:0]  sdi0;
    logic        sdo0, csn0, clk_en0, reg_done0, cnv_valid0, overrun0, busy0;
    logic        start_acq0, start_reg0, cnv_ready0, clear_ovr0;
    logic [23:0] reg_cmd0;
    logic [7:0]  reg_rdata0;
    logic [31:0] cnv_data0;

    logic [0:0]  sdi1;
    logic        sdo1, csn1, clk_en1, reg_done1, cnv_valid1, overrun1, busy1;
    logic        start_acq1, start_reg1, cnv_ready1, clear_ovr1;
    logic [7:0]  reg_rdata1;
    logic [31:0] cnv_data1;

    adc_spi_engine dut0 (
        .clk(clk), .reset(reset), .spi_sdi(sdi0), .spi_sdo(sdo0), .spi_csn(csn0),
        .spi_clk_en(clk_en0), .start_acq(start_acq0), .start_reg(start_reg0),
        .reg_cmd(reg_cmd0), .reg_rdata(reg_rdata0), .reg_done(reg_done0),
        .cnv_data(cnv_data0), .cnv_valid(cnv_valid0), .cnv_ready(cnv_ready0),
        .overrun(overrun0), .clear_overrun(clear_ovr0), .busy(busy0)
    );

    adc_spi_engine #(.NUM_SDI(1), .CS_SETUP(0), .CS_HOLD(0)) dut1 (
        .clk(clk), .reset(reset), .spi_sdi(sdi1), .spi_sdo(sdo1), .spi_csn(csn1),
        .spi_clk_en(clk_en1), .start_acq(start_acq1), .start_reg(start_reg1),
        .reg_cmd(reg_cmd0), .reg_rdata(reg_rdata1), .reg_done(reg_done1),
        .cnv_data(cnv_data1), .cnv_valid(cnv_valid1), .cnv_ready(cnv_ready1),
        .overrun(overrun1), .clear_overrun(clear_ovr1), .busy(busy1)
    );

    typedef struct {
        int          en;
        int          low;
        bit          chk_sdo;
        logic [23:0] cmd;
    } frame_t;

    frame_t      fq0[$];
    logic [31:0] cq0[$];
    logic [31:0] cq1[$];
    logic [7:0]  rq0[$];

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    int frames1 = 0;

    logic        drv_reg0 = 1'b0;
    logic [31:0] drv_data0 = '0;
    logic [23:0] drv_rpat0 = '0;
    logic [31:0] drv_data1 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Lane drivers: present the next beat whenever the SPI clock is enabled this cycle
    initial begin
        int idx0;
        idx0 = 0;
        sdi0 = '0;
        forever begin
            tick;
            if (clk_en0 === 1'b1 && idx0 < 24) begin
                if (drv_reg0) begin
                    sdi0 = {3'b000, drv_rpat0[23-idx0]};
                end else if (idx0 < 8) begin
                    for (int i = 0; i < 4; i++) sdi0[i] = drv_data0[31-4*idx0-i];
                end
                idx0++;
            end else begin
                idx0 = 0;
                sdi0 = '0;
            end
        end
    end

    initial begin
        int idx1;
        idx1 = 0;
        sdi1 = '0;
        forever begin
            tick;
            if (clk_en1 === 1'b1 && idx1 < 32) begin
                sdi1[0] = drv_data1[31-idx1];
                idx1++;
            end else begin
                idx1 = 0;
                sdi1 = '0;
            end
        end
    end

    // Frame monitor for dut0: CSn low length, enabled clocks, sdo bits, CSn gap
    initial begin
        int low, en, gap;
        bit in_frame, seen;
        logic [23:0] sdo_cap;
        frame_t f;
        low = 0; en = 0; gap = 0; in_frame = 0; seen = 0; sdo_cap = '0;
        forever begin
            @(negedge clk);
            if (csn0 === 1'b0) begin
                if (!in_frame) begin
                    in_frame = 1;
                    if (seen) chk("csn_gap_min_hold", (gap >= 2), 1'b1);
                    low = 0; en = 0; sdo_cap = '0;
                end
                low++;
                if (clk_en0 === 1'b1) begin
                    en++;
                    sdo_cap = {sdo_cap[22:0], sdo0};
                end
            end else begin
                if (in_frame) begin
                    in_frame = 0;
                    seen = 1;
                    gap = 0;
                    if (fq0.size() == 0) begin
                        chk("unexpected_frame", 1'b1, 1'b0);
                    end else begin
                        f = fq0.pop_front();
                        chk("frame_clk_en_cycles", en, f.en);
                        chk("frame_csn_low_cycles", low, f.low);
                        if (f.chk_sdo) chk("reg_sdo_bits", sdo_cap, f.cmd);
                    end
                end
                gap++;
            end
        end
    end

    // Output monitors: pop expected result on every accepted result / register completion
    always @(negedge clk) begin
        if (cnv_valid0 === 1'b1 && cnv_ready0 === 1'b1) begin
            if (cq0.size() == 0) chk("unexpected_cnv0", 1'b1, 1'b0);
            else chk("cnv_data0", cnv_data0, cq0.pop_front());
        end
        if (reg_done0 === 1'b1) begin
            done_cnt++;
            if (rq0.size() == 0) chk("unexpected_reg_done", 1'b1, 1'b0);
            else chk("reg_rdata", reg_rdata0, rq0.pop_front());
        end
        if (cnv_valid1 === 1'b1 && cnv_ready1 === 1'b1) begin
            if (cq1.size() == 0) chk("unexpected_cnv1", 1'b1, 1'b0);
            else chk("cnv_data1", cnv_data1, cq1.pop_front());
        end
    end

    initial begin
        int low1, en1;
        bit inf1;
        low1 = 0; en1 = 0; inf1 = 0;
        forever begin
            @(negedge clk);
            if (csn1 === 1'b0) begin
                if (!inf1) begin
                    inf1 = 1; low1 = 0; en1 = 0;
                    chk("d1_clk_en_in_start_cycle", clk_en1, 1'b1);
                end
                low1++;
                if (clk_en1 === 1'b1) en1++;
            end else if (inf1) begin
                inf1 = 0;
                frames1++;
                chk("d1_clk_en_cycles", en1, 32);
                chk("d1_csn_low_cycles", low1, 33);
                chk("d1_immediate_idle", busy1, 1'b0);
            end
        end
    end

    task automatic wait_idle0(input int max);
        int i;
        i = 0;
        while (busy0 !== 1'b0 && i < max) begin
            tick;
            i++;
        end
        chk("d0_idle_timeout", busy0, 1'b0);
    endtask

    task automatic wait_en0(input logic v, input int max);
        int i;
        i = 0;
        while (clk_en0 !== v && i < max) begin
            tick;
            i++;
        end
        chk("d0_clk_en_wait", clk_en0, v);
    endtask

    task automatic go_acq0(input logic [31:0] d);
        drv_reg0 = 1'b0;
        drv_data0 = d;
        start_acq0 = 1'b1;
        tick;
        start_acq0 = 1'b0;
    endtask

    task automatic go_reg0(input logic [23:0] cmd, input logic [7:0] rd);
        drv_reg0 = 1'b1;
        drv_rpat0 = {16'h0000, rd};
        reg_cmd0 = cmd;
        start_reg0 = 1'b1;
        tick;
        start_reg0 = 1'b0;
    endtask

    task automatic pulse_ready0;
        cnv_ready0 = 1'b1;
        tick;
        cnv_ready0 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int d, falls, n;
        logic prev;
        reset = 1'b1;
        start_acq0 = 0; start_reg0 = 0; reg_cmd0 = '0; cnv_ready0 = 0; clear_ovr0 = 0;
        start_acq1 = 0; start_reg1 = 0; cnv_ready1 = 1; clear_ovr1 = 0;
        repeat (3) tick;
        chk("rst_csn", csn0, 1'b1);
        chk("rst_sdo", sdo0, 1'b0);
        chk("rst_clk_en", clk_en0, 1'b0);
        chk("rst_reg_done", reg_done0, 1'b0);
        chk("rst_cnv_valid", cnv_valid0, 1'b0);
        chk("rst_overrun", overrun0, 1'b0);
        chk("rst_cnv_data", cnv_data0, 32'h0);
        chk("rst_reg_rdata", reg_rdata0, 8'h00);
        chk("rst_busy", busy0, 1'b1);
        reset = 1'b0;
        tick;
        chk("idle_after_reset", busy0, 1'b0);

        // Basic acquisition; result held until accepted
        fq0.push_back('{8, 10, 1'b0, 24'h0});
        cq0.push_back(32'hA5C31E7F);
        go_acq0(32'hA5C31E7F);
        wait_idle0(100);
        repeat (5) tick;
        chk("valid_held", cnv_valid0, 1'b1);
        chk("no_overrun_single", overrun0, 1'b0);
        pulse_ready0;
        chk("valid_cleared", cnv_valid0, 1'b0);

        // Register write+read
        d = done_cnt;
        fq0.push_back('{24, 26, 1'b1, 24'h8012FF});
        rq0.push_back(8'h5A);
        go_reg0(24'h8012FF, 8'h5A);
        wait_idle0(100);
        chk("reg_done_once", done_cnt - d, 1);
        chk("reg_no_cnv_valid", cnv_valid0, 1'b0);

        // Overrun: second result overwrites an unread one
        fq0.push_back('{8, 10, 1'b0, 24'h0});
        fq0.push_back('{8, 10, 1'b0, 24'h0});
        cq0.push_back(32'h3C960FF1);
        go_acq0(32'h11223344);
        wait_idle0(100);
        go_acq0(32'h3C960FF1);
        wait_idle0(100);
        chk("overrun_set", overrun0, 1'b1);
        pulse_ready0;
        chk("overrun_sticky", overrun0, 1'b1);
        clear_ovr0 = 1'b1;
        tick;
        clear_ovr0 = 1'b0;
        chk("overrun_cleared", overrun0, 1'b0);

        // Accept at the completion cycle: new data loads, no overrun
        fq0.push_back('{8, 10, 1'b0, 24'h0});
        fq0.push_back('{8, 10, 1'b0, 24'h0});
        cq0.push_back(32'h01234567);
        cq0.push_back(32'hFEDCBA98);
        go_acq0(32'h01234567);
        wait_idle0(100);
        go_acq0(32'hFEDCBA98);
        wait_en0(1'b1, 50);
        wait_en0(1'b0, 50);
        cnv_ready0 = 1'b1;
        tick;
        cnv_ready0 = 1'b0;
        wait_idle0(100);
        chk("no_overrun_on_accept", overrun0, 1'b0);
        chk("valid_after_accept", cnv_valid0, 1'b1);
        pulse_ready0;

        // Both starts: acquisition wins, register request dropped
        d = done_cnt;
        fq0.push_back('{8, 10, 1'b0, 24'h0});
        cq0.push_back(32'h5555AAAA);
        drv_reg0 = 1'b0;
        drv_data0 = 32'h5555AAAA;
        reg_cmd0 = 24'hFFFFFF;
        start_acq0 = 1'b1;
        start_reg0 = 1'b1;
        tick;
        start_acq0 = 1'b0;
        start_reg0 = 1'b0;
        wait_idle0(100);
        repeat (3) tick;
        chk("both_start_no_reg_done", done_cnt - d, 0);
        pulse_ready0;

        // Back-to-back frames with start held high
        fq0.push_back('{8, 10, 1'b0, 24'h0});
        fq0.push_back('{8, 10, 1'b0, 24'h0});
        cq0.push_back(32'h9E3779B9);
        cq0.push_back(32'h9E3779B9);
        cnv_ready0 = 1'b1;
        drv_reg0 = 1'b0;
        drv_data0 = 32'h9E3779B9;
        start_acq0 = 1'b1;
        falls = 0;
        prev = csn0;
        for (int i = 0; i < 200 && falls < 2; i++) begin
            tick;
            if (prev === 1'b1 && csn0 === 1'b0) falls++;
            prev = csn0;
        end
        start_acq0 = 1'b0;
        chk("b2b_two_starts", falls, 2);
        wait_idle0(100);
        repeat (3) tick;
        cnv_ready0 = 1'b0;
        chk("b2b_no_overrun", overrun0, 1'b0);

        // 1-lane, zero setup/hold instance
        drv_data1 = 32'hC001D00D;
        cq1.push_back(32'hC001D00D);
        start_acq1 = 1'b1;
        tick;
        start_acq1 = 1'b0;
        for (int i = 0; i < 100 && busy1 !== 1'b0; i++) tick;
        chk("d1_idle_timeout", busy1, 1'b0);
        repeat (3) tick;

        // Reset in the middle of a register frame
        d = done_cnt;
        fq0.push_back('{5, 6, 1'b0, 24'h0});
        go_reg0(24'h123456, 8'hC3);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (clk_en0 === 1'b1) n++;
            if (n == 5) break;
            tick;
        end
        chk("reset_reached_xfer", n, 5);
        reset = 1'b1;
        tick;
        chk("abort_csn", csn0, 1'b1);
        chk("abort_clk_en", clk_en0, 1'b0);
        chk("abort_busy", busy0, 1'b1);
        chk("abort_sdo", sdo0, 1'b0);
        chk("abort_reg_done", reg_done0, 1'b0);
        chk("abort_cnv_valid", cnv_valid0, 1'b0);
        tick;
        reset = 1'b0;
        repeat (4) tick;
        chk("abort_no_done_pulse", done_cnt - d, 0);
        chk("abort_idle", busy0, 1'b0);

        chk("cnv0_queue_drained", cq0.size(), 0);
        chk("cnv1_queue_drained", cq1.size(), 0);
        chk("reg_queue_drained", rq0.size(), 0);
        chk("frame_queue_drained", fq0.size(), 0);
        chk("d1_frame_count", frames1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_spi_engine.md
Name: adc_spi_engine

Overview:
- Parametrised successor to the single-ADC SPI controller. Drives one ADC over a multi-lane SPI link.
- Performs conversion readouts and 24-bit register writes/reads.
- Chip-select setup and hold times are configurable; conversion results leave through a valid/ready output register with overrun detection.
- Sits between the acquisition sequencer (start strobes) and the ADC pins; SPI clock gating is done at top level from spi_clk_en.

Parameters:
NUM_SDI, 4, number of SDI lanes; CNV_BITS must be divisible by it
CNV_BITS, 32, conversion result width
REG_BITS, 24, register command frame length
REG_DATA_BITS, 8, trailing frame bits captured from spi_sdi[0] as readback data
CS_SETUP, 1, cycles CSn is low with clock disabled before the first SPI clock (0 allowed)
CS_HOLD, 2, minimum cycles CSn is high between frames (0 allowed)

Ports:
clk  in  1  system and SPI source clock
reset  in  1  synchronous, active-high reset
spi_sdi  in  NUM_SDI  ADC serial data lanes
spi_sdo  out  1  ADC serial data in
spi_csn  out  1  chip select, active low
spi_clk_en  out  1  enable for the gated SPI clock buffer
start_acq  in  1  request conversion readout (sampled in IDLE)
start_reg  in  1  request register frame (sampled in IDLE)
reg_cmd  in  REG_BITS  register frame, MSB sent first, latched at start
reg_rdata  out  REG_DATA_BITS  readback captured in the last register frame
reg_done  out  1  one-cycle pulse at register frame end
cnv_data  out  CNV_BITS  conversion result
cnv_valid  out  1  result available
cnv_ready  in  1  consumer accepts result
overrun  out  1  sticky: unread result overwritten
clear_overrun  in  1  clears overrun
busy  out  1  state != IDLE, or reset asserted

Behaviour:
- Reset values: spi_csn=1; spi_sdo=0; spi_clk_en=0; reg_done=0; cnv_valid=0; overrun=0; cnv_data=0; reg_rdata=0; state IDLE. Reset mid-frame aborts immediately with no done pulse and no cnv_valid.
- States: IDLE, SETUP, XFER, HOLD. Counter width is $clog2 of the largest of CNV_BITS/NUM_SDI, REG_BITS, CS_SETUP and CS_HOLD, plus 1.
- IDLE start:
  - start_acq has priority when both starts are high; the other request is dropped.
  - On start: spi_csn<=0 and the mode is latched.
  - Transfer counter loads N: N = CNV_BITS/NUM_SDI for acquisition, N = REG_BITS for a register frame.
  - Register frame: spi_sdo<=reg_cmd[REG_BITS-1].
  - Acquisition: spi_sdo<=0 and the internal shift register is cleared.
  - Next state: if CS_SETUP=0, go to XFER with spi_clk_en<=1 in the same cycle; otherwise go to SETUP with spi_clk_en=0.
- SETUP: lasts CS_SETUP cycles. spi_clk_en<=1 on the last of them, then go to XFER.
- XFER, while count>0, each cycle:
  - count decrements.
  - Acquisition: shift <= {shift[CNV_BITS-NUM_SDI-1:0], lanes}, with spi_sdi[0] placed at the MSB of each NUM_SDI chunk.
  - Register frame: spi_sdo takes the next command bit (0 after the last bit); spi_sdi[0] shifts into reg_rdata during the final REG_DATA_BITS cycles.
  - When count==1: spi_clk_en<=0.
- XFER, at count==0:
  - spi_csn<=1.
  - Acquisition completion: cnv_data<=shift; cnv_valid<=1. If cnv_valid was 1 and cnv_ready was 0 in that cycle, overrun<=1.
  - Register completion: reg_done pulses for 1 cycle.
  - Next state: HOLD if CS_HOLD>0, else IDLE.
- HOLD: CSn stays high for CS_HOLD cycles, then IDLE. Starts arriving during HOLD are ignored; requesters hold start until busy=0.
- Frame timing from start (CS_SETUP=s): spi_csn is low for s+N+1 cycles and spi_clk_en is high for exactly N cycles.
- Output handshake:
  - cnv_valid && cnv_ready clears cnv_valid.
  - If completion and the handshake happen in the same cycle, the new data loads, cnv_valid stays 1, and there is no overrun.
  - cnv_data is stable while cnv_valid=1, except on overwrite.
- overrun clears only on reset or clear_overrun. If a set and a clear happen in the same cycle, the set wins.

Test Plan:
- Acquisition, defaults: lanes drive a nibble pattern giving 0xA5C3_1E7F (sdi[0] = MSB of each nibble) -> cnv_data=0xA5C31E7F; clk_en high exactly 8 cycles; CSn low 10 cycles; cnv_valid held until cnv_ready.
- Register write+read: reg_cmd=0x8012FF, ADC returns 0x5A on sdi[0] in the last 8 clocks -> sdo bit sequence matches 0x8012FF MSB-first; reg_rdata=0x5A; reg_done pulses once.
- Overrun: two acquisitions with cnv_ready=0 -> second data visible, overrun=1; clear_overrun -> 0. Repeat with cnv_ready=1 pulsed at the second completion -> overrun stays 0.
- Simultaneous start_acq and start_reg -> acquisition runs, no register frame; back-to-back starts -> CSn high at least CS_HOLD cycles between frames.
- Parametrisation: NUM_SDI=1 and CS_SETUP=0/CS_HOLD=0 -> 32 clock enables, clk_en asserted in the start cycle, immediate return to IDLE.
- Reset asserted mid-XFER -> next cycle: CSn=1, clk_en=0, busy=1 during reset, no reg_done or cnv_valid.
